// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV M-extension unit: funct3 encodings,
// FSM states and the W-result sign-extension helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational radix-2 restoring division step: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference if it did not go negative.
module muldiv_div_step #(
    parameter int unsigned W = 64
) (
    input  logic [W:0]   i_rem,
    input  logic [W-1:0] i_dvsr,
    input  logic         i_bit,
    output logic [W:0]   o_rem,
    output logic         o_q
);

    logic [W+1:0] w_shift;
    logic [W+1:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {2'b00, i_dvsr};
    assign o_q     = ~w_diff[W+1];
    assign o_rem   = o_q ? w_diff[W:0] : w_shift[W:0];

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV M-extension execute unit: MUL_BPC-bit-per-cycle shift-add multiplier
// and radix-2 restoring divider on sign-stripped magnitudes, valid/ready handshake.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned MUL_BPC   = 4,
    parameter int unsigned DIV_EARLY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] op_1_i,
    input  logic [XLEN-1:0] op_2_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned PW = 2 * XLEN;

    function automatic logic [XLEN-1:0] wres(input logic [31:0] x);
        logic [63:0] t;
        t = sext32(x);
        return t[XLEN-1:0];
    endfunction

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_op;
    logic            r_word, r_neg, r_rneg;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_acc, r_mcand;
    logic [XLEN-1:0] r_mplier, r_quo, r_dvsr, r_result;
    logic [XLEN:0]   r_rem;

    logic            w_word, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic            w_b_zero, w_ovf, w_fast, w_accept;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_fast_val, w_fast_res;
    logic [CW-1:0]   w_steps;

    // ---------------- operand preparation at accept ----------------
    assign w_word  = (XLEN == 64) ? word_i : 1'b0;
    assign w_a_sgn = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign w_b_sgn = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);

    always_comb begin
        w_a_ext = op_1_i;
        w_b_ext = op_2_i;
        if (w_word) begin
            w_a_ext = w_a_sgn ? wres(op_1_i[31:0]) : XLEN'(op_1_i[31:0]);
            w_b_ext = w_b_sgn ? wres(op_2_i[31:0]) : XLEN'(op_2_i[31:0]);
        end
    end

    assign w_a_neg = w_a_sgn & w_a_ext[XLEN-1];
    assign w_b_neg = w_b_sgn & w_b_ext[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

    assign w_b_zero = (w_b_ext == '0);
    assign w_ovf    = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                      (w_word ? ((op_1_i[31:0] == 32'h8000_0000) && (op_2_i[31:0] == '1))
                              : ((op_1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_2_i == '1)));
    assign w_fast   = (DIV_EARLY != 0) && op_i[2] && (w_b_zero || w_ovf);

    // op_i[1] selects REM/REMU among the divide ops
    always_comb begin
        if (w_b_zero) w_fast_val = op_i[1] ? w_a_ext : '1;
        else          w_fast_val = op_i[1] ? '0 : w_a_ext;
        w_fast_res = w_word ? wres(w_fast_val[31:0]) : w_fast_val;
    end

    assign w_steps = op_i[2] ? (w_word ? CW'(32) : CW'(XLEN))
                             : (w_word ? CW'(32 / MUL_BPC) : CW'(XLEN / MUL_BPC));

    assign w_accept = (r_state == IDLE) && req_valid_i && !flush_i;

    // ---------------- multiplier step ----------------
    logic [PW-1:0]   w_pp, w_acc_nxt, w_prod;
    logic [XLEN-1:0] w_mul_sel, w_mul_res;

    always_comb begin
        w_pp = '0;
        for (int unsigned b = 0; b < MUL_BPC; b++) begin
            if (r_mplier[b]) w_pp = w_pp + (r_mcand << b);
        end
        w_acc_nxt = r_acc + w_pp;
        w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
        if (r_op == OP_MUL) w_mul_sel = w_prod[XLEN-1:0];
        else                w_mul_sel = r_word ? XLEN'(w_prod[63:32]) : w_prod[PW-1:XLEN];
        w_mul_res = r_word ? wres(w_mul_sel[31:0]) : w_mul_sel;
    end

    // ---------------- divider step ----------------
    logic [XLEN:0]   w_rem_nxt;
    logic            w_qbit;
    logic [XLEN-1:0] w_quo_nxt, w_div_sel, w_div_res;

    muldiv_div_step #(.W(XLEN)) u_div_step (
        .i_rem  (r_rem),
        .i_dvsr (r_dvsr),
        .i_bit  (r_quo[XLEN-1]),
        .o_rem  (w_rem_nxt),
        .o_q    (w_qbit)
    );

    // dividend bits leave the top of r_quo while quotient bits enter at the bottom
    always_comb begin
        w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};
        if (r_op[1]) w_div_sel = r_rneg ? -w_rem_nxt[XLEN-1:0] : w_rem_nxt[XLEN-1:0];
        else         w_div_sel = r_neg  ? -w_quo_nxt : w_quo_nxt;
        w_div_res = r_word ? wres(w_div_sel[31:0]) : w_div_sel;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (req_valid_i) w_state_nxt = w_fast ? DONE : (op_i[2] ? DIV : MUL);
            MUL:  if (r_cnt == CW'(1)) w_state_nxt = DONE;
            DIV:  if (r_cnt == CW'(1)) w_state_nxt = DONE;
            DONE: if (resp_ready_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush_i) w_state_nxt = IDLE;
    end

    assign req_ready_o  = (r_state == IDLE) && rst;
    assign resp_valid_o = (r_state == DONE);
    assign result_o     = r_result;

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op     <= '0;
            r_word   <= 1'b0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (!flush_i) begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op     <= op_i;
                    r_word   <= w_word;
                    r_cnt    <= w_steps;
                    r_acc    <= '0;
                    r_mcand  <= PW'(w_a_mag);
                    r_mplier <= w_b_mag;
                    r_rem    <= '0;
                    r_quo    <= w_word ? (w_a_mag << (XLEN - 32)) : w_a_mag;
                    r_dvsr   <= w_b_mag;
                    // a zero divisor must give an all-ones quotient whatever the dividend sign
                    r_neg    <= (w_a_neg ^ w_b_neg) & ~(op_i[2] & w_b_zero);
                    r_rneg   <= w_a_neg;
                    if (w_fast) r_result <= w_fast_res;
                end
                MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << MUL_BPC;
                    r_mplier <= r_mplier >> MUL_BPC;
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_result <= w_mul_res;
                end
                DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_result <= w_div_res;
                end
                default: ;
            endcase
        end
    end

endmodule
